// File: rtl/seg7_scan.sv
`timescale 1ns/1ps
// seg7_scan: multiplexed seven-segment display scanner.
//
// A prescaler divides clk_i into digit slots of PRESCALE cycles. Each slot
// drives one digit, taken from shadow registers loaded by load_i. The first
// GUARD cycles of every slot keep all digit selects off so the previous
// digit's segments do not ghost onto the new one. Leading zeros can be
// blanked. frame_o pulses once per full scan.
//
// Ports
//   clk_i      system clock, rising edge
//   rst_n_i    asynchronous active-low reset
//   din_i      hex nibbles, [3:0] is digit 0
//   dp_i       decimal point per digit
//   load_i     capture strobe for din_i / dp_i
//   lzb_i      leading-zero blanking enable
//   en_i       scan enable
//   seg7_o     segments a..g (bit0 = a), registered
//   segdp_o    decimal-point segment, registered
//   digit_o    one-hot digit select, registered
//   frame_o    one-cycle pulse at each scan wrap, registered
module seg7_scan #(
   parameter int NDIGITS    = 4,
   parameter int PRESCALE   = 50000,
   parameter int GUARD      = 2,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic                   clk_i,
   input  logic                   rst_n_i,
   input  logic [4*NDIGITS-1:0]   din_i,
   input  logic [NDIGITS-1:0]     dp_i,
   input  logic                   load_i,
   input  logic                   lzb_i,
   input  logic                   en_i,
   output logic [6:0]             seg7_o,
   output logic                   segdp_o,
   output logic [NDIGITS-1:0]     digit_o,
   output logic                   frame_o
);

   localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
   localparam int PW = $clog2(PRESCALE);

   // XOR with these turns an active-high pattern into the output polarity.
   localparam logic [6:0]         SEG_OFF = {7{ACTIVE_LOW}};
   localparam logic [NDIGITS-1:0] DIG_OFF = {NDIGITS{ACTIVE_LOW}};

   logic [4*NDIGITS-1:0] din_q, din_d;
   logic [NDIGITS-1:0]   dp_q, dp_d;
   logic [PW-1:0]        presc_q, presc_d;
   logic [IW-1:0]        idx_q, idx_d;
   logic [6:0]           seg7_q, seg7_d;
   logic                 segdp_q, segdp_d;
   logic [NDIGITS-1:0]   digit_q, digit_d;
   logic                 frame_q, frame_d;

   logic                 presc_last;
   logic                 idx_last;
   logic [3:0]           nib;
   logic                 dp_sel;
   logic                 blank;
   logic [6:0]           seg_ah;
   logic                 digit_on;

   always_comb begin
      presc_last = (presc_q == PW'(PRESCALE - 1));
      idx_last   = (idx_q == IW'(NDIGITS - 1));
      presc_d    = presc_q;
      idx_d      = idx_q;
      if (en_i) begin
         if (presc_last) begin
            presc_d = '0;
            idx_d   = idx_last ? '0 : idx_q + 1'b1;
         end else begin
            presc_d = presc_q + 1'b1;
         end
      end
      din_d = load_i ? din_i : din_q;
      dp_d  = load_i ? dp_i  : dp_q;
   end

   // Select the current nibble and decide blanking: a non-zero digit at or
   // above idx means idx is not a leading zero. Digit 0 is never blanked.
   always_comb begin
      nib    = 4'h0;
      dp_sel = 1'b0;
      blank  = lzb_i && (idx_q != '0);
      for (int i = 0; i < NDIGITS; i++) begin
         if (IW'(i) == idx_q) begin
            nib    = din_q[4*i +: 4];
            dp_sel = dp_q[i];
         end
         if ((IW'(i) >= idx_q) && (din_q[4*i +: 4] != 4'h0)) begin
            blank = 1'b0;
         end
      end
   end

   always_comb begin
      seg_ah = 7'h00;
      case (nib)
         4'h0: seg_ah = 7'h3F;
         4'h1: seg_ah = 7'h06;
         4'h2: seg_ah = 7'h5B;
         4'h3: seg_ah = 7'h4F;
         4'h4: seg_ah = 7'h66;
         4'h5: seg_ah = 7'h6D;
         4'h6: seg_ah = 7'h7D;
         4'h7: seg_ah = 7'h07;
         4'h8: seg_ah = 7'h7F;
         4'h9: seg_ah = 7'h6F;
         4'hA: seg_ah = 7'h77;
         4'hB: seg_ah = 7'h7C;
         4'hC: seg_ah = 7'h39;
         4'hD: seg_ah = 7'h5E;
         4'hE: seg_ah = 7'h79;
         4'hF: seg_ah = 7'h71;
         default: seg_ah = 7'h00;
      endcase
   end

   always_comb begin
      digit_on = en_i && (presc_q >= PW'(GUARD));
      seg7_d   = blank ? SEG_OFF : (seg_ah ^ SEG_OFF);
      segdp_d  = dp_sel ^ ACTIVE_LOW;
      digit_d  = digit_on ? ((NDIGITS'(1) << idx_q) ^ DIG_OFF) : DIG_OFF;
      frame_d  = en_i && presc_last && idx_last;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         din_q   <= '0;
         dp_q    <= '0;
         presc_q <= '0;
         idx_q   <= '0;
         seg7_q  <= SEG_OFF;
         segdp_q <= ACTIVE_LOW;
         digit_q <= DIG_OFF;
         frame_q <= 1'b0;
      end else begin
         din_q   <= din_d;
         dp_q    <= dp_d;
         presc_q <= presc_d;
         idx_q   <= idx_d;
         seg7_q  <= seg7_d;
         segdp_q <= segdp_d;
         digit_q <= digit_d;
         frame_q <= frame_d;
      end
   end

   assign seg7_o  = seg7_q;
   assign segdp_o = segdp_q;
   assign digit_o = digit_q;
   assign frame_o = frame_q;

endmodule

// File: tb/tb_seg7_scan.sv
`timescale 1ns/1ps
module tb_seg7_scan;
   localparam int N = 4;
   localparam int P = 4;
   localparam int G = 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic [15:0] din;
   logic [3:0]  dp;
   logic        load, lzb, en;
   logic [6:0]  seg7;
   logic        segdp;
   logic [3:0]  digit;
   logic        frame;

   seg7_scan #(.NDIGITS(N), .PRESCALE(P), .GUARD(G), .ACTIVE_LOW(1'b1)) dut (
      .clk_i(clk), .rst_n_i(rst_n), .din_i(din), .dp_i(dp), .load_i(load),
      .lzb_i(lzb), .en_i(en), .seg7_o(seg7), .segdp_o(segdp),
      .digit_o(digit), .frame_o(frame)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model: t counts enabled cycles since reset; slot and digit
   // position follow from it arithmetically.
   int         t;
   logic [3:0] sh [4];
   logic [3:0] shdp;
   int         cyc = 0;
   int         nframes = 0;
   int         last_frame = -1;
   int         last_gap = 0;
   logic [6:0] frame_seg [4];

   logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic rst_pulse();
      rst_n = 1'b0;
      #0.5;
      chk("rst_seg7", {25'd0, seg7}, 32'h7F);
      chk("rst_segdp", {31'd0, segdp}, 32'h1);
      chk("rst_digit", {28'd0, digit}, 32'hF);
      chk("rst_frame", {31'd0, frame}, 32'h0);
      #0.5;
      rst_n = 1'b1;
      t = 0;
      for (int i = 0; i < N; i++) sh[i] = 4'h0;
      shdp = 4'h0;
   endtask

   task automatic step(input logic e, input logic ld, input logic lz,
                       input logic [15:0] d, input logic [3:0] p);
      int pr, ix;
      bit blank;
      logic [6:0] eseg;
      logic       edp;
      logic [3:0] edig;
      logic       efr;
      en = e; load = ld; lzb = lz; din = d; dp = p;
      pr = t % P;
      ix = (t / P) % N;
      blank = lz && (ix > 0);
      for (int j = ix; j < N; j++) if (sh[j] != 4'h0) blank = 1'b0;
      eseg = blank ? 7'h7F : ~seg_tab[sh[ix]];
      edp  = ~shdp[ix];
      edig = (!e || pr < G) ? 4'hF : ~(4'b0001 << ix);
      efr  = e && (pr == P - 1) && (ix == N - 1);
      @(posedge clk);
      #1;
      cyc++;
      chk("seg7", {25'd0, seg7}, {25'd0, eseg});
      chk("segdp", {31'd0, segdp}, {31'd0, edp});
      chk("digit", {28'd0, digit}, {28'd0, edig});
      chk("frame", {31'd0, frame}, {31'd0, efr});
      if (ld) begin
         for (int i = 0; i < N; i++) sh[i] = d[4*i +: 4];
         shdp = p;
      end
      if (e) t++;
      if (frame === 1'b1) begin
         nframes++;
         if (last_frame >= 0) last_gap = cyc - last_frame;
         last_frame = cyc;
      end
      for (int i = 0; i < N; i++) if (digit[i] === 1'b0) frame_seg[i] = seg7;
   endtask

   initial begin
      logic [15:0] rd;
      int          guard_cnt;
      rst_n = 1'b1; en = 1'b0; load = 1'b0; lzb = 1'b0; din = '0; dp = '0;
      #2;
      rst_pulse();

      // Free-running scan of zeros.
      for (int k = 0; k < 16; k++) step(1, 0, 0, 16'h0, 4'h0);

      // Load A5F3 with DP on digit 2, then observe one full frame.
      step(1, 1, 0, 16'hA5F3, 4'b0100);
      for (int k = 0; k < 16; k++) step(1, 0, 0, 16'h0, 4'h0);
      chk("a5f3_d0", {25'd0, frame_seg[0]}, 32'b0110000);
      chk("a5f3_d1", {25'd0, frame_seg[1]}, 32'b0001110);
      chk("a5f3_d2", {25'd0, frame_seg[2]}, 32'b0010010);
      chk("a5f3_d3", {25'd0, frame_seg[3]}, 32'b0001000);

      // Leading-zero blanking.
      step(1, 1, 1, 16'h0070, 4'h0);
      for (int k = 0; k < 16; k++) step(1, 0, 1, 16'h0, 4'h0);
      chk("lzb70_d3", {25'd0, frame_seg[3]}, 32'h7F);
      chk("lzb70_d2", {25'd0, frame_seg[2]}, 32'h7F);
      chk("lzb70_d1", {25'd0, frame_seg[1]}, 32'b1111000);
      chk("lzb70_d0", {25'd0, frame_seg[0]}, 32'b1000000);
      step(1, 1, 1, 16'h0000, 4'h0);
      for (int k = 0; k < 16; k++) step(1, 0, 1, 16'h0, 4'h0);
      chk("lzb00_d3", {25'd0, frame_seg[3]}, 32'h7F);
      chk("lzb00_d1", {25'd0, frame_seg[1]}, 32'h7F);
      chk("lzb00_d0", {25'd0, frame_seg[0]}, 32'b1000000);

      // Frame pulses and EN freeze.
      rst_pulse();
      nframes = 0; last_frame = -1; last_gap = 0;
      for (int k = 0; k < 48; k++) step(1, 0, 0, 16'h0, 4'h0);
      chk("frames3", nframes, 3);
      chk("frame_gap16", last_gap, 16);
      step(1, 0, 0, 16'h0, 4'h0);
      step(1, 0, 0, 16'h0, 4'h0);
      for (int k = 0; k < 5; k++) step(0, 0, 0, 16'h0, 4'h0);
      guard_cnt = 0;
      while (nframes < 4 && guard_cnt < 40) begin
         step(1, 0, 0, 16'h0, 4'h0);
         guard_cnt++;
      end
      chk("frame4_seen", {31'd0, nframes == 4}, 32'h1);
      chk("frame_gap21", last_gap, 21);

      // LOAD coinciding with a slot advance.
      while (t % P != P - 1) step(1, 0, 0, 16'h0, 4'h0);
      step(1, 1, 0, 16'h8E21, 4'b1010);
      for (int k = 0; k < 6; k++) step(1, 0, 0, 16'h0, 4'h0);

      // Short reset pulse mid-slot, then restart.
      rst_pulse();
      for (int k = 0; k < 8; k++) step(1, 0, 0, 16'h0, 4'h0);

      // Randomized run against the model.
      for (int k = 0; k < 500; k++) begin
         rd = 16'($urandom) >> (4 * $urandom_range(0, 4));
         if ($urandom_range(0, 150) == 0) rst_pulse();
         step($urandom_range(0, 9) != 0, $urandom_range(0, 7) == 0,
              1'($urandom), rd, 4'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
